// File: rtl/orient_hist_peak.sv
// Orientation histogram over one keypoint window, then a linear scan for the dominant bin.
// Result strobe in the cycle NBIN+1 after the last-sample accept; in_ready low during SCAN/DONE, drops flagged sticky.
// Optional HIST_SMOOTH_EN: scan compares a circular [1 2 1]/4 smoothed histogram instead of raw bins.
module orient_hist_peak #(
    parameter int NORM  = 20,
    parameter int NBIN  = 36,
    parameter int ACC_W = 28,
    parameter int BIN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NORM-1:0]  in_mag,
    input  logic [NORM-1:0]  in_ang,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [BIN_W-1:0] out_bin,
    output logic [ACC_W-1:0] out_peak,
    output logic             out_valid,
    output logic             drop_err
);
    typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

    localparam int PW = NORM + BIN_W;
    localparam int MW = (NORM > ACC_W) ? NORM : ACC_W;
    localparam logic [ACC_W-1:0] SAT      = '1;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBIN - 1);

    logic [ACC_W-1:0] hist [NBIN];
    state_t           state;
    logic             rdy;
    logic [BIN_W-1:0] idx;
    logic [BIN_W-1:0] max_bin;
    logic [ACC_W-1:0] max_val;

    logic [PW-1:0]    prod;
    logic [BIN_W-1:0] wr_bin;
    logic [NORM-1:0]  mag_u;
    logic [MW:0]      sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             accept;
    logic [ACC_W-1:0] scan_val;
    logic             gt;

    assign in_ready = rdy;
    assign accept   = in_valid & rdy;

    // Angle scaled by NBIN, integer part is the bin; full-scale angle lands in NBIN-1.
    assign prod    = PW'(in_ang) * PW'(NBIN);
    assign wr_bin  = BIN_W'(prod >> NORM);
    assign mag_u   = in_mag[NORM-1] ? '0 : in_mag;
    assign sum     = (MW+1)'(hist[wr_bin]) + (MW+1)'(mag_u);
    assign acc_nxt = (sum > (MW+1)'(SAT)) ? SAT : sum[ACC_W-1:0];

`ifdef HIST_SMOOTH_EN
    logic [BIN_W-1:0] idx_prev;
    logic [BIN_W-1:0] idx_next;
    logic [ACC_W+1:0] ssum;

    assign idx_prev = (idx == '0) ? LAST_BIN : idx - 1'b1;
    assign idx_next = (idx == LAST_BIN) ? '0 : idx + 1'b1;
    assign ssum     = (ACC_W+2)'(hist[idx_prev]) + (ACC_W+2)'({hist[idx], 1'b0})
                    + (ACC_W+2)'(hist[idx_next]);
    assign scan_val = ACC_W'(ssum >> 2);
`else
    assign scan_val = hist[idx];
`endif

    // Strict compare keeps the lowest index on ties.
    assign gt = scan_val > max_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACCUM;
            rdy       <= 1'b1;
            idx       <= '0;
            max_bin   <= '0;
            max_val   <= '0;
            out_bin   <= '0;
            out_peak  <= '0;
            out_valid <= 1'b0;
            drop_err  <= 1'b0;
            for (int k = 0; k < NBIN; k++) hist[k] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && !rdy) drop_err <= 1'b1;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        hist[wr_bin] <= acc_nxt;
                        if (in_last) begin
                            state   <= SCAN;
                            rdy     <= 1'b0;
                            idx     <= '0;
                            max_bin <= '0;
                            max_val <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (gt) begin
                        max_val <= scan_val;
                        max_bin <= idx;
                    end
                    idx <= idx + 1'b1;
                    if (idx == LAST_BIN) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_bin   <= gt ? idx : max_bin;
                        out_peak  <= gt ? scan_val : max_val;
                    end
                end
                DONE: begin
                    for (int k = 0; k < NBIN; k++) hist[k] <= '0;
                    state <= ACCUM;
                    rdy   <= 1'b1;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_orient_hist_peak.sv
// Directed bench: default 28-bit instance plus an 8-bit-accumulator instance sharing stimulus.
module tb_orient_hist_peak;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] in_mag = '0;
    logic [19:0] in_ang = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready, out_valid, drop_err;
    logic [5:0]  out_bin;
    logic [27:0] out_peak;
    logic        in_ready8, out_valid8, drop_err8;
    logic [5:0]  out_bin8;
    logic [7:0]  out_peak8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    orient_hist_peak dut (
        .clk(clk), .rst(rst), .in_mag(in_mag), .in_ang(in_ang),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_bin(out_bin), .out_peak(out_peak), .out_valid(out_valid),
        .drop_err(drop_err)
    );

    orient_hist_peak #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_mag(in_mag), .in_ang(in_ang),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready8),
        .out_bin(out_bin8), .out_peak(out_peak8), .out_valid(out_valid8),
        .drop_err(drop_err8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [19:0] mag, input logic [19:0] ang, input logic last);
        in_mag   = mag;
        in_ang   = ang;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // n0 = clock edges already seen, counting the last-sample accept edge as 1.
    task automatic wait_result(input string tag, input int n0, input logic [5:0] eb,
                               input logic [27:0] ep, input logic check8, input logic [7:0] ep8);
        int n = n0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 37);
        chk({tag, "_bin"}, out_bin, eb);
        chk({tag, "_peak"}, out_peak, ep);
        chk({tag, "_rdy_done"}, in_ready, 1'b0);
        if (check8) begin
            chk({tag, "_vld8"}, out_valid8, 1'b1);
            chk({tag, "_bin8"}, out_bin8, eb);
            chk({tag, "_peak8"}, out_peak8, ep8);
        end
        @(negedge clk);
        chk({tag, "_vld_width"}, out_valid, 1'b0);
        chk({tag, "_rdy_back"}, in_ready, 1'b1);
        chk({tag, "_bin_hold"}, out_bin, eb);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst_bin", out_bin, 0);
        chk("rst_peak", out_peak, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_drop", drop_err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rdy", in_ready, 1);

        // Single sample at 90 degrees.
        send(20'd100, 20'h40000, 1'b1);
        wait_result("single", 1, 6'd9, 28'd100, 1'b1, 8'd100);
        chk("no_drop_yet", drop_err, 0);

        // Tie between bins 3 and 20 resolves to the lower index.
        send(20'd50, 20'h18000, 1'b0);
        send(20'd50, 20'h90000, 1'b1);
        wait_result("tie", 1, 6'd3, 28'd50, 1'b1, 8'd50);

        // Negative magnitude clamps; full-scale angle maps to the top bin.
        send(20'hFFFFB, 20'h00000, 1'b0);
        send(20'd1, 20'hFFFFF, 1'b1);
        wait_result("clamp", 1, 6'd35, 28'd1, 1'b1, 8'd1);

        // Back-to-back same-bin samples; 8-bit instance saturates.
        send(20'd200, 20'h40000, 1'b0);
        send(20'd200, 20'h40000, 1'b0);
        send(20'd200, 20'h40000, 1'b1);
        wait_result("sat", 1, 6'd9, 28'd600, 1'b1, 8'd255);
        send(20'd7, 20'h00000, 1'b1);
        wait_result("cleared", 1, 6'd0, 28'd7, 1'b1, 8'd7);

        // Samples offered during SCAN are dropped and flagged.
        send(20'd30, 20'h80000, 1'b1);
        in_mag   = 20'd500;
        in_ang   = 20'h00000;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("drop_flag", drop_err, 1);
        chk("drop_rdy", in_ready, 0);
        wait_result("drop", 6, 6'd18, 28'd30, 1'b1, 8'd30);
        send(20'd3, 20'h40000, 1'b1);
        wait_result("after_drop", 1, 6'd9, 28'd3, 1'b1, 8'd3);
        chk("drop_sticky", drop_err, 1);

        // Reset in the middle of SCAN aborts the window.
        send(20'd40, 20'h00000, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_bin", out_bin, 0);
        chk("abort_peak", out_peak, 0);
        chk("abort_vld", out_valid, 0);
        chk("abort_drop", drop_err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rdy", in_ready, 1);
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_vld", seen, 0);
        send(20'd10, 20'h80000, 1'b1);
        wait_result("fresh", 1, 6'd18, 28'd10, 1'b1, 8'd10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/orient_hist_peak.md
Name: orient_hist_peak

Overview:
- Downstream consumer of the CORDIC post-correction stage in the SIFT Get_Feature path.
- Takes per-pixel gradient magnitude and angle (20-bit, full circle = 2^20) for one keypoint window and bins them into an orientation histogram.
- After the window's last sample, scans the histogram and reports the dominant-orientation bin and its weight.

Parameters:
NORM, 20, magnitude/angle bit width (matches CORDIC output)
NBIN, 36, number of orientation bins (each 2^20/NBIN angle units)
ACC_W, 28, per-bin accumulator width (unsigned)
BIN_W, 6, width of bin index, must hold NBIN-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_mag  in  NORM  signed gradient magnitude (corrected CORDIC x)
in_ang  in  NORM  angle, unsigned phase; 0x40000=90deg, 0x80000=180deg
in_valid  in  1  sample valid
in_last  in  1  final sample of the window, qualified by in_valid
in_ready  out  1  block accepts samples this cycle
out_bin  out  BIN_W  peak bin index
out_peak  out  ACC_W  peak bin value
out_valid  out  1  one-cycle result strobe
drop_err  out  1  sticky: a sample was presented while in_ready=0

Behaviour:
- Clock clk; reset rst asynchronous, active-low. Reset: all bins 0, state ACCUM, out_bin=0, out_peak=0, out_valid=0, drop_err=0. in_ready=1 after reset release.
- Accept = in_valid & in_ready. No stall path upstream; samples with in_valid=1, in_ready=0 are discarded and set drop_err (cleared only by reset).
- Bin mapping: bin = (unsigned(in_ang) * NBIN) >> NORM, range 0..NBIN-1; in_ang=0xFFFFF maps to NBIN-1.
- Magnitude: negative in_mag clamped to 0; otherwise zero-extended to ACC_W.
- Accumulate: bin += mag, saturating at 2^ACC_W-1. Registered, one sample per cycle, back-to-back same-bin samples must both count.
- FSM:
  - ACCUM: in_ready=1. Accept with in_last=1 accumulates that sample too, then -> SCAN.
  - SCAN: in_ready=0. One bin per cycle, index 0..NBIN-1, over NBIN cycles. Running max uses strict greater-than, so the lowest index wins ties. All-zero histogram gives bin 0, peak 0. -> DONE.
  - DONE: one cycle. out_valid=1, out_bin/out_peak registered. All bins cleared on the exiting edge. -> ACCUM.
- Latency: out_valid asserted in the cycle NBIN+1 clocks after the in_last accept edge. in_ready returns the cycle after DONE. Window-to-window gap is NBIN+1 cycles.
- out_bin/out_peak hold until the next DONE. out_valid=0 except in DONE.
- Reset mid-window or mid-SCAN aborts. Partial histogram discarded, no out_valid.

Optional Feature:
- Macro HIST_SMOOTH_EN.
- Defined: during SCAN, each compared value is s[k] = (h[k-1] + 2*h[k] + h[k+1]) >> 2.
  - Indices are circular: k-1 of 0 is NBIN-1, k+1 of NBIN-1 is 0.
  - Sum is computed at ACC_W+2 bits; the result fits ACC_W.
  - out_peak reports the smoothed value.
  - Latency unchanged.
- Undefined: raw bin values compared; no smoothing logic present.

Test Plan:
1. Single sample mag=100, ang=0x40000, last=1 -> out_bin=9, out_peak=100, out_valid exactly 37 clocks after accept, one cycle wide. With HIST_SMOOTH_EN: bin 9, peak 50.
2. Tie: mag=50 ang=0x18000 (bin 3), then mag=50 ang=0x90000 (bin 20, last) -> out_bin=3, out_peak=50.
3. Clamp/wrap: mag=0xFFFFB (-5) ang=0x00000, then mag=1 ang=0xFFFFF last -> out_bin=35, out_peak=1.
4. Saturation, ACC_W=8: three samples mag=200 ang=0x40000 (last on third) -> out_peak=255, out_bin=9. A following window with a single sample mag=7 in bin 0 -> out_peak=7 (bins cleared).
5. Drop: in_valid=1 held during SCAN -> in_ready=0, drop_err rises and stays 1. Current result unchanged; next window's histogram unaffected.
6. Reset asserted mid-SCAN -> outputs 0, no out_valid. After release, in_ready=1 and a fresh window with mag=10 ang=0x80000 gives out_bin=18, out_peak=10.
